// File: rtl/timer_pkg.sv
// Shared definitions for the 64-bit timer: FSM states, TCR field
// positions, prescaler limits and the divider mask helper.
package timer_pkg;

  localparam int unsigned DIV_MAX_DEFAULT = 8;
  localparam int unsigned DIV_W           = 4;
  localparam int unsigned DIV_CNT_W       = 8;
  localparam int unsigned CNT_W           = 64;

  localparam int unsigned TCR_EN_BIT      = 0;
  localparam int unsigned TCR_DIV_EN_BIT  = 1;
  localparam int unsigned TCR_DIV_LSB     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Terminal prescaler count for a divide-by-2^val period.
  function automatic logic [DIV_CNT_W-1:0] div_mask(input logic [DIV_W-1:0] val);
    logic [DIV_CNT_W:0] full;
    full = (DIV_CNT_W+1)'(1) << val;
    return DIV_CNT_W'(full - (DIV_CNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: produces one tick per 2^div_val run cycles,
// or every run cycle when the divider is off.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 bypass;

  assign bypass = !div_en || (div_val == '0);
  assign tick   = run && (bypass || (div_cnt == div_mask(div_val)));

  // Phase counter: cleared on request, frozen when not running, wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      if (tick || bypass) div_cnt <= '0;
      else                div_cnt <= div_cnt + DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: owns TCR and the 64-bit count, runs the
// prescaler and freezes counting during a debug halt handshake.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DIV_MAX = DIV_MAX_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tcr_wr_sel,
  input  logic             tdr0_wr_sel,
  input  logic             tdr1_wr_sel,
  input  logic [31:0]      tim_pwdata,
  input  logic [3:0]       tim_pstrb,
  input  logic             dbg_mode,
  input  logic             halt_req,
  output logic [CNT_W-1:0] cnt,
  output logic             timer_en,
  output logic             div_en,
  output logic [DIV_W-1:0] div_val,
  output logic             halt_ack,
  output logic             tcr_err
);

  state_t             state, state_nxt;
  logic               wr_en, wr_div_en;
  logic [DIV_W-1:0]   wr_div_val;
  logic               bad_div, busy_change, tcr_accept, tcr_reject;
  logic               en_post, disable_wr, halt_in, tick;
  logic [CNT_W-1:0]   cnt_nxt;

  // Decode a TCR write: candidate field values and the rejection rules.
  always_comb begin
    wr_en       = tim_pstrb[0] ? tim_pwdata[TCR_EN_BIT]     : timer_en;
    wr_div_en   = tim_pstrb[0] ? tim_pwdata[TCR_DIV_EN_BIT] : div_en;
    wr_div_val  = tim_pstrb[1] ? tim_pwdata[TCR_DIV_LSB +: DIV_W] : div_val;
    bad_div     = tim_pstrb[1] &&
                  ({28'd0, tim_pwdata[TCR_DIV_LSB +: DIV_W]} > DIV_MAX);
    busy_change = timer_en && wr_en &&
                  ((wr_div_en != div_en) || (wr_div_val != div_val));
    tcr_reject  = tcr_wr_sel && (bad_div || busy_change);
    tcr_accept  = tcr_wr_sel && !(bad_div || busy_change);
    en_post     = tcr_accept ? wr_en : timer_en;
    disable_wr  = tcr_accept && timer_en && !wr_en;
  end

  // TCR fields and the one-cycle rejection pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= '0;
      tcr_err  <= 1'b0;
    end else begin
      tcr_err <= tcr_reject;
      if (tcr_accept) begin
        timer_en <= wr_en;
        div_en   <= wr_div_en;
        div_val  <= wr_div_val;
      end
    end
  end

  assign halt_in = dbg_mode && halt_req;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state: halt dominates, otherwise follow the post-write enable.
  always_comb begin
    state_nxt = state;
    if (halt_in) begin
      state_nxt = HALT;
    end else begin
      case (state)
        IDLE:    state_nxt = en_post ? RUN : IDLE;
        RUN:     state_nxt = en_post ? RUN : IDLE;
        HALT:    state_nxt = en_post ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign halt_ack = (state == HALT);

  timer_prescaler u_prescaler (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .run     (state == RUN),
    .clear   ((state == IDLE) || disable_wr),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  // Next count: a TDR write replaces the increment for that cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (tdr0_wr_sel || tdr1_wr_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (tim_pstrb[i]) begin
          if (tdr0_wr_sel) cnt_nxt[8*i +: 8]      = tim_pwdata[8*i +: 8];
          if (tdr1_wr_sel) cnt_nxt[32 + 8*i +: 8] = tim_pwdata[8*i +: 8];
        end
      end
    end else if (tick) begin
      cnt_nxt = cnt + 64'd1;
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt <= '0;
    else            cnt <= cnt_nxt;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        tcr_wr_sel = 1'b0;
  logic        tdr0_wr_sel = 1'b0;
  logic        tdr1_wr_sel = 1'b0;
  logic [31:0] tim_pwdata = '0;
  logic [3:0]  tim_pstrb = '0;
  logic        dbg_mode = 1'b0;
  logic        halt_req = 1'b0;
  logic [63:0] cnt;
  logic        timer_en, div_en, halt_ack, tcr_err;
  logic [3:0]  div_val;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  timer_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tcr_wr_sel  (tcr_wr_sel),
    .tdr0_wr_sel (tdr0_wr_sel),
    .tdr1_wr_sel (tdr1_wr_sel),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .dbg_mode    (dbg_mode),
    .halt_req    (halt_req),
    .cnt         (cnt),
    .timer_en    (timer_en),
    .div_en      (div_en),
    .div_val     (div_val),
    .halt_ack    (halt_ack),
    .tcr_err     (tcr_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Count every cycle in which a rejection pulse is visible.
  always @(negedge sys_clk) if (tcr_err) err_pulses++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One bus cycle: drive the selects for a single edge, then release.
  task automatic applyStimulus(input logic tcr, input logic tdr0, input logic tdr1,
                               input logic [31:0] data, input logic [3:0] strb);
    tcr_wr_sel  = tcr;
    tdr0_wr_sel = tdr0;
    tdr1_wr_sel = tdr1;
    tim_pwdata  = data;
    tim_pstrb   = strb;
    step(1);
    tcr_wr_sel  = 1'b0;
    tdr0_wr_sel = 1'b0;
    tdr1_wr_sel = 1'b0;
    tim_pwdata  = '0;
    tim_pstrb   = '0;
  endtask

  initial begin
    // Reset values
    step(3);
    checkOutput("rst_cnt", cnt, 64'd0);
    checkOutput("rst_en", {63'd0, timer_en}, 64'd0);
    checkOutput("rst_div_val", {60'd0, div_val}, 64'd0);
    checkOutput("rst_halt_ack", {63'd0, halt_ack}, 64'd0);
    checkOutput("rst_tcr_err", {63'd0, tcr_err}, 64'd0);
    sys_rst_n = 1'b1;
    step(2);

    // Free-running count with divider off
    applyStimulus(1, 0, 0, 32'h1, 4'hF);
    checkOutput("en_set", {63'd0, timer_en}, 64'd1);
    checkOutput("en_cnt0", cnt, 64'd0);
    step(10);
    checkOutput("run10_cnt", cnt, 64'd10);
    checkOutput("run10_halt_ack", {63'd0, halt_ack}, 64'd0);
    checkOutput("run10_no_err", 64'(err_pulses), 64'd0);

    // Disable: the increment in the write cycle still lands, then hold
    applyStimulus(1, 0, 0, 32'h0, 4'hF);
    checkOutput("dis_en", {63'd0, timer_en}, 64'd0);
    checkOutput("dis_cnt", cnt, 64'd11);
    step(3);
    checkOutput("dis_hold", cnt, 64'd11);

    // Divide by 4
    applyStimulus(1, 0, 0, 32'h0203, 4'h3);
    checkOutput("div_val2", {60'd0, div_val}, 64'd2);
    checkOutput("div_en1", {63'd0, div_en}, 64'd1);
    step(3);
    checkOutput("div_pre_tick", cnt, 64'd11);
    step(1);
    checkOutput("div_tick1", cnt, 64'd12);
    step(4);
    checkOutput("div_tick2", cnt, 64'd13);

    // Divider change while enabled is rejected
    applyStimulus(1, 0, 0, 32'h0303, 4'h3);
    checkOutput("busy_err", {63'd0, tcr_err}, 64'd1);
    checkOutput("busy_div_val", {60'd0, div_val}, 64'd2);
    step(1);
    checkOutput("busy_err_pulse", {63'd0, tcr_err}, 64'd0);

    // Halt mid-period (phase 2 of 4), hold, then resume at saved phase
    dbg_mode = 1'b1;
    halt_req = 1'b1;
    step(1);
    checkOutput("halt_ack_on", {63'd0, halt_ack}, 64'd1);
    checkOutput("halt_cnt", cnt, 64'd13);
    step(20);
    checkOutput("halt_frozen", cnt, 64'd13);
    checkOutput("halt_ack_held", {63'd0, halt_ack}, 64'd1);
    halt_req = 1'b0;
    step(1);
    checkOutput("halt_ack_off", {63'd0, halt_ack}, 64'd0);
    checkOutput("release_cnt", cnt, 64'd13);
    step(1);
    checkOutput("resume_phase", cnt, 64'd14);
    step(4);
    checkOutput("resume_period", cnt, 64'd15);

    // halt_req without dbg_mode is ignored
    dbg_mode = 1'b0;
    halt_req = 1'b1;
    step(1);
    checkOutput("nodbg_ack", {63'd0, halt_ack}, 64'd0);
    step(3);
    checkOutput("nodbg_cnt", cnt, 64'd16);
    halt_req = 1'b0;

    // Disable via lane 0 only, then div_val limit checks while idle
    applyStimulus(1, 0, 0, 32'h0, 4'h1);
    checkOutput("dis2_en", {63'd0, timer_en}, 64'd0);
    checkOutput("dis2_cnt", cnt, 64'd16);
    applyStimulus(1, 0, 0, 32'h0900, 4'h2);
    checkOutput("div9_err", {63'd0, tcr_err}, 64'd1);
    checkOutput("div9_kept", {60'd0, div_val}, 64'd2);
    applyStimulus(1, 0, 0, 32'h0800, 4'h2);
    checkOutput("div8_ok", {63'd0, tcr_err}, 64'd0);
    checkOutput("div8_val", {60'd0, div_val}, 64'd8);

    // 64-bit wrap
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 4'hF);
    checkOutput("tdr1_wr", cnt, 64'hFFFF_FFFF_0000_0010);
    applyStimulus(0, 1, 0, 32'hFFFF_FFFE, 4'hF);
    checkOutput("tdr0_wr", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(1, 0, 0, 32'h1, 4'h1);
    checkOutput("wrap_en", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1);
    checkOutput("wrap_max", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    checkOutput("wrap_zero", cnt, 64'd0);

    // TDR write in a tick cycle: write wins, increment dropped
    applyStimulus(0, 1, 0, 32'h0000_AB00, 4'h2);
    checkOutput("tdr_tick_win", cnt, 64'h0000_0000_0000_AB00);
    step(1);
    checkOutput("tdr_tick_next", cnt, 64'h0000_0000_0000_AB01);

    // Asynchronous reset mid-count
    applyStimulus(0, 1, 0, 32'h0000_1234, 4'h3);
    checkOutput("pre_rst_cnt", cnt, 64'h1234);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("arst_cnt", cnt, 64'd0);
    checkOutput("arst_en", {63'd0, timer_en}, 64'd0);
    checkOutput("arst_div_val", {60'd0, div_val}, 64'd0);
    checkOutput("arst_halt_ack", {63'd0, halt_ack}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(3);
    checkOutput("post_rst_idle", cnt, 64'd0);
    checkOutput("post_rst_en", {63'd0, timer_en}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Counter sequencing controller for the 64-bit timer. It owns the timer control register (TCR) and the 64-bit count register (TDR1:TDR0), runs the prescaler, and freezes counting on a debug halt handshake. It drives `cnt` to the compare/interrupt logic, which raises the interrupt when `cnt` equals the compare value. The APB decoder supplies the per-register write selects and data; read-back muxing is done elsewhere.

## Interface
- `DIV_MAX`, 8: largest legal `div_val`; a prescale of 2^8 = 256 cycles per tick.
- `sys_clk` in 1: the only clock; all state changes on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `tcr_wr_sel` in 1: TCR write strobe for this cycle.
- `tdr0_wr_sel` in 1: write strobe for `cnt[31:0]`.
- `tdr1_wr_sel` in 1: write strobe for `cnt[63:32]`.
- `tim_pwdata` in 32: write data.
- `tim_pstrb` in 4: byte strobes.
- `dbg_mode` in 1: debug mode active.
- `halt_req` in 1: debug halt request, level.
- `cnt` out 64: current count.
- `timer_en` out 1: TCR[0].
- `div_en` out 1: TCR[1].
- `div_val` out 4: TCR[11:8].
- `halt_ack` out 1: high while the block is in HALT.
- `tcr_err` out 1: one-cycle pulse when a TCR write is rejected.

## Operation
- **TCR fields:** `timer_en` = bit0, `div_en` = bit1 (byte lane 0); `div_val` = bits[11:8] (byte lane 1). A field updates only when its byte strobe is set.
- **TCR write rejection:** the whole write is rejected, TCR unchanged and `tcr_err` = 1 for one cycle, if either condition holds:
  - the lane-1 value written to `div_val` exceeds DIV_MAX;
  - current `timer_en` = 1, the resulting `timer_en` stays 1, and the write changes `div_en` or `div_val`.
- **Disable:** a write that takes `timer_en` from 1 to 0 is always accepted. It clears the prescaler counter; `cnt` holds its value.
- **FSM states:** IDLE, RUN, HALT. Reset state is IDLE.
- **FSM transitions:** next state uses the post-write `timer_en` of the same edge.
  - Any state goes to HALT when `dbg_mode & halt_req`.
  - HALT goes to RUN if `timer_en` = 1, otherwise IDLE, when `dbg_mode & halt_req` = 0.
  - IDLE goes to RUN when `timer_en` = 1; RUN goes to IDLE when `timer_en` = 0.
- **Prescaler:** 8-bit `div_cnt` advances only in RUN.
  - If `div_en` = 0 or `div_val` = 0, `tick` = 1 every RUN cycle.
  - Otherwise `tick` = 1 when `div_cnt == 2^div_val - 1`, and `div_cnt` then wraps to 0.
  - HALT freezes `div_cnt`; IDLE clears it.
- **Counter:** on `tick`, `cnt <= cnt + 1`, modulo 2^64; `0xFFFF_FFFF_FFFF_FFFF` wraps to 0.
- **TDR writes:** a TDR0/TDR1 write merges the strobed bytes into the selected half. In that cycle the write wins and the increment is dropped. TDR writes are accepted in every state, including HALT.
- **Register access in HALT:** TCR writes are also accepted in HALT. The `timer_en` 1-to-0 change still clears `div_cnt`.

## Timing
- **Reset values:** `cnt` = 0, TCR = 0, `timer_en` = `div_en` = 0, `div_val` = 0, `halt_ack` = 0, `tcr_err` = 0, state IDLE, `div_cnt` = 0.
- **Enable:** a TCR write setting `timer_en` = 1 at edge k gives state RUN after k. First increment is at edge k+1 with the divider off, or at edge k+2^div_val with it on.
- **Halt entry:** `dbg_mode & halt_req` sampled high at edge k gives `halt_ack` = 1 after k. An increment due at edge k still occurs; no increments from k+1.
- **Halt release:** `halt_req` sampled low at edge m gives `halt_ack` = 0 after m. Counting resumes at edge m+1 from the frozen `div_cnt`.
- **Write latency:** `tcr_err` and all register updates appear one edge after the write cycle.
- **Asynchronous reset:** asserting `sys_rst_n` mid-count immediately forces all reset values.

## Structure
- **Package `timer_pkg`:** FSM state enum (IDLE/RUN/HALT), TCR bit positions, DIV_MAX, and address-independent field widths. Shared with the interrupt and APB blocks.
- **Sub-module `timer_prescaler`:** holds `div_cnt`. Inputs are run, clear, `div_en` and `div_val`; output is `tick`.

## Test plan
- Reset, write TCR = 0x1 → after 10 cycles `cnt` = 10; `halt_ack` = 0; `tcr_err` never set.
- TCR = 0x0203 (div 4) → `cnt` increments every 4 cycles; then a TCR write of 0x0303 with `timer_en` staying 1 → `tcr_err` pulse, `div_val` stays 2.
- TCR write with `div_val` = 9 while IDLE → rejected, `tcr_err` pulse, TCR stays 0.
- Write TDR1 = 0xFFFF_FFFF and TDR0 = 0xFFFF_FFFE, then run → `cnt` reaches 0xFFFF_FFFF_FFFF_FFFF, then 0 on the next tick. A TDR0 write in a tick cycle → written value kept, no increment.
- RUN with div 4; raise `dbg_mode` and `halt_req` mid-period → `halt_ack` next edge, `cnt` and `div_cnt` frozen for 20 cycles. Drop `halt_req` → counting resumes at the saved phase. `halt_req` without `dbg_mode` → ignored.
- Assert `sys_rst_n` low while RUN with `cnt` = 0x1234 → all outputs at reset values immediately; state IDLE after release.
